// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic stage registers between CPU pipeline stages:
// occupancy states, write-back payload widths and RF write-select encodings.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // pc4(32) + alu_c(32) + wR(5) + rdo(32) + rf_wsel(2)
  localparam int WB_PAYLOAD_W = 103;
  localparam int WB_WE_W      = 2;

  // Register-file write-data source select carried in the payload
  localparam logic [1:0] RF_WSEL_ALU  = 2'd0;
  localparam logic [1:0] RF_WSEL_DRAM = 2'd1;
  localparam logic [1:0] RF_WSEL_PC4  = 2'd2;
  localparam logic [1:0] RF_WSEL_IMM  = 2'd3;

  // Upstream may only push while the skid slot is free.
  function automatic logic st_ready(input state_e st);
    return (st != ST_TWO);
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle of one elastic pipeline stage; slave is the stage's view,
// master is the view of whatever drives and consumes it.
interface pipe_stage_skid_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = WB_PAYLOAD_W,
  parameter int WE_W   = WB_WE_W,
  parameter int CNT_W  = 16
) ();

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [WE_W-1:0]   in_we;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [WE_W-1:0]   out_we;
  logic [CNT_W-1:0]  bubble_cnt;

  modport slave (
    input  flush, in_valid, in_data, in_we, out_ready,
    output in_ready, out_valid, out_data, out_we, bubble_cnt
  );

  modport master (
    output flush, in_valid, in_data, in_we, out_ready,
    input  in_ready, out_valid, out_data, out_we, bubble_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value; cleared only by reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = W'(1'b1);

  logic [W-1:0] cnt_r;

  // Count register with saturation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
    end else if (inc && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  assign q = cnt_r;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic two-slot (main + skid) stage register with registered in_ready,
// synchronous flush and a saturating downstream-idle (bubble) counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = WB_PAYLOAD_W,
  parameter int WE_W   = WB_WE_W,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pipe_stage_skid_if.slave       bus
);

  state_e            state_r;
  state_e            state_nxt_s;
  logic              ready_r;
  logic              valid_r;
  logic              valid_nxt_s;
  logic [DATA_W-1:0] main_data_r;
  logic [DATA_W-1:0] skid_data_r;
  logic [WE_W-1:0]   main_we_r;
  logic [WE_W-1:0]   skid_we_r;
  logic [WE_W-1:0]   main_we_nxt_s;
  logic              accept_s;
  logic              take_s;
  logic              load_in_s;
  logic              load_skid_s;
  logic              pop_skid_s;
  logic              bubble_inc_s;
  logic [CNT_W-1:0]  bubble_cnt_s;

  assign accept_s = bus.in_valid & ready_r;
  assign take_s   = valid_r & bus.out_ready;

  // Next-state and slot-load decode; flush overrides every handshake
  always_comb begin
    state_nxt_s = state_r;
    load_in_s   = 1'b0;
    load_skid_s = 1'b0;
    pop_skid_s  = 1'b0;
    if (bus.flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_nxt_s = ST_ONE;
            load_in_s   = 1'b1;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && take_s) begin
            state_nxt_s = ST_ONE;
            load_in_s   = 1'b1;
          end else if (accept_s) begin
            state_nxt_s = ST_TWO;
            load_skid_s = 1'b1;
          end else if (take_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_TWO: begin
          if (take_s) begin
            state_nxt_s = ST_ONE;
            pop_skid_s  = 1'b1;
          end else begin
            state_nxt_s = ST_TWO;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end
  end

  // Write enables are stored pre-gated so out_we is already zero when the main slot is empty
  always_comb begin
    valid_nxt_s   = (state_nxt_s != ST_EMPTY);
    main_we_nxt_s = {WE_W{1'b0}};
    if (!valid_nxt_s) begin
      main_we_nxt_s = {WE_W{1'b0}};
    end else if (load_in_s) begin
      main_we_nxt_s = bus.in_we;
    end else if (pop_skid_s) begin
      main_we_nxt_s = skid_we_r;
    end else begin
      main_we_nxt_s = main_we_r;
    end
  end

  // Control state and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_EMPTY;
      ready_r   <= 1'b1;
      valid_r   <= 1'b0;
      main_we_r <= {WE_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      ready_r   <= st_ready(state_nxt_s);
      valid_r   <= valid_nxt_s;
      main_we_r <= main_we_nxt_s;
    end
  end

  // Payload slots; contents persist after pop or flush, only validity changes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data_r <= {DATA_W{1'b0}};
      skid_data_r <= {DATA_W{1'b0}};
      skid_we_r   <= {WE_W{1'b0}};
    end else begin
      if (load_in_s) begin
        main_data_r <= bus.in_data;
      end else if (pop_skid_s) begin
        main_data_r <= skid_data_r;
      end
      if (load_skid_s) begin
        skid_data_r <= bus.in_data;
        skid_we_r   <= bus.in_we;
      end
    end
  end

  assign bubble_inc_s = bus.out_ready & ~valid_r;

  sat_counter #(
    .W (CNT_W)
  ) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (bubble_inc_s),
    .q   (bubble_cnt_s)
  );

  assign bus.in_ready   = ready_r;
  assign bus.out_valid  = valid_r;
  assign bus.out_data   = main_data_r;
  assign bus.out_we     = main_we_r;
  assign bus.bubble_cnt = bubble_cnt_s;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and scoreboarded checks of pipe_stage_skid, plus a narrow-counter
// instance for bubble saturation.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int DW = WB_PAYLOAD_W;
  localparam int WW = WB_WE_W;

  typedef struct {
    logic [DW-1:0] d;
    logic [WW-1:0] we;
  } ent_t;

  logic clk;
  logic rst;
  int   vec_cnt;
  int   err_cnt;
  logic [15:0] exp_bub;
  ent_t sb[$];

  pipe_stage_skid_if #(.DATA_W(DW), .WE_W(WW), .CNT_W(16)) bus ();
  pipe_stage_skid_if #(.DATA_W(8), .WE_W(1), .CNT_W(3)) bus2 ();

  pipe_stage_skid #(.DATA_W(DW), .WE_W(WW), .CNT_W(16)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );

  pipe_stage_skid #(.DATA_W(8), .WE_W(1), .CNT_W(3)) dut2 (
    .clk (clk), .rst (rst), .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference bubble count, sampled mid-cycle when inputs and outputs are stable
  always @(negedge clk or posedge rst) begin
    if (rst) exp_bub = 16'd0;
    else if (bus.out_ready && !bus.out_valid && exp_bub != 16'hFFFF) exp_bub = exp_bub + 16'd1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [WW-1:0] we,
                       input logic rdy, input logic fl);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_we     = we;
    bus.out_ready = rdy;
    bus.flush     = fl;
  endtask

  initial begin
    int seq;
    int cyc;
    logic exp_take;
    logic exp_acc;
    logic [DW-1:0] rd;
    ent_t e;
    vec_cnt = 0;
    err_cnt = 0;
    rst = 1'b1;
    drive(1'b0, {DW{1'b0}}, 2'b00, 1'b0, 1'b0);
    bus2.flush = 1'b0; bus2.in_valid = 1'b0; bus2.in_data = 8'h00;
    bus2.in_we = 1'b0; bus2.out_ready = 1'b0;
    #3;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_we", bus.out_we, 2'b00);
    check("rst_out_data", bus.out_data, {DW{1'b0}});
    check("rst_bubble", bus.bubble_cnt, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Bubbles: downstream idle-waiting
    bus.out_ready = 1'b1;
    bus2.out_ready = 1'b1;
    repeat (5) step();
    check("bubble_5", bus.bubble_cnt, 16'd5);
    check("bubble2_5", bus2.bubble_cnt, 3'd5);
    bus.out_ready = 1'b0;
    repeat (5) step();
    check("bubble2_sat", bus2.bubble_cnt, 3'd7);
    check("bubble_hold", bus.bubble_cnt, 16'd5);

    // Streaming at full rate
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DW'(i), 2'b01, 1'b1, 1'b0);
      step();
      check($sformatf("stream_data_%0d", i), bus.out_data, DW'(i));
      check("stream_valid", bus.out_valid, 1'b1);
      check("stream_ready", bus.in_ready, 1'b1);
      check("stream_we", bus.out_we, 2'b01);
    end
    drive(1'b0, {DW{1'b0}}, 2'b00, 1'b1, 1'b0);
    step();
    check("stream_drain_valid", bus.out_valid, 1'b0);
    check("stream_drain_we", bus.out_we, 2'b00);

    // Skid: A appears, then two stalled cycles
    drive(1'b1, DW'(8'hA), 2'b10, 1'b1, 1'b0);
    step();
    check("skid_a", bus.out_data, DW'(8'hA));
    drive(1'b1, DW'(8'hB), 2'b10, 1'b0, 1'b0);
    step();
    check("skid_a_hold", bus.out_data, DW'(8'hA));
    check("skid_full_ready", bus.in_ready, 1'b0);
    drive(1'b1, DW'(8'hC), 2'b10, 1'b0, 1'b0);
    step();
    check("skid_a_hold2", bus.out_data, DW'(8'hA));
    check("skid_full_ready2", bus.in_ready, 1'b0);
    drive(1'b1, DW'(8'hC), 2'b10, 1'b1, 1'b0);
    step();
    check("skid_b", bus.out_data, DW'(8'hB));
    check("skid_drain_ready", bus.in_ready, 1'b1);
    step();
    check("skid_c", bus.out_data, DW'(8'hC));
    check("skid_c_valid", bus.out_valid, 1'b1);
    drive(1'b0, {DW{1'b0}}, 2'b00, 1'b1, 1'b0);
    step();
    check("skid_empty", bus.out_valid, 1'b0);

    // Flush from TWO with an input offered
    drive(1'b1, DW'(8'hE), 2'b11, 1'b0, 1'b0);
    step();
    drive(1'b1, DW'(8'hF), 2'b11, 1'b0, 1'b0);
    step();
    check("fl_two_ready", bus.in_ready, 1'b0);
    check("fl_two_we", bus.out_we, 2'b11);
    drive(1'b1, DW'(8'hD), 2'b11, 1'b0, 1'b1);
    step();
    check("fl_valid", bus.out_valid, 1'b0);
    check("fl_we", bus.out_we, 2'b00);
    check("fl_ready", bus.in_ready, 1'b1);
    drive(1'b0, {DW{1'b0}}, 2'b00, 1'b1, 1'b0);
    step();
    check("fl_no_d", bus.out_valid, 1'b0);
    // Flush from ONE while in_ready=1 still drops the offered entry
    drive(1'b1, DW'(8'hE2), 2'b01, 1'b0, 1'b0);
    step();
    check("fl1_valid_pre", bus.out_valid, 1'b1);
    drive(1'b1, DW'(8'hD), 2'b11, 1'b0, 1'b1);
    step();
    check("fl1_valid", bus.out_valid, 1'b0);
    drive(1'b0, {DW{1'b0}}, 2'b00, 1'b1, 1'b0);
    step();
    check("fl1_no_d", bus.out_valid, 1'b0);

    // Asynchronous reset with both slots full
    drive(1'b1, DW'(8'h61), 2'b11, 1'b0, 1'b0);
    step();
    drive(1'b1, DW'(8'h62), 2'b11, 1'b0, 1'b0);
    step();
    check("arst_pre_ready", bus.in_ready, 1'b0);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_valid", bus.out_valid, 1'b0);
    check("arst_ready", bus.in_ready, 1'b1);
    check("arst_we", bus.out_we, 2'b00);
    check("arst_bubble", bus.bubble_cnt, 16'd0);
    check("arst_data", bus.out_data, {DW{1'b0}});
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Random traffic against a reference FIFO of depth two
    seq = 0;
    cyc = 0;
    sb.delete();
    while (seq < 1000 && cyc < 20000) begin
      cyc++;
      rd = {DW{1'b0}};
      rd[31:0] = 32'(seq);
      rd[95:64] = $urandom;
      drive(1'($urandom_range(0, 1)), rd, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
      check("rnd_valid", bus.out_valid, (sb.size() > 0));
      check("rnd_ready", bus.in_ready, (sb.size() < 2));
      if (sb.size() > 0) begin
        check("rnd_data", bus.out_data, sb[0].d);
        check("rnd_we", bus.out_we, sb[0].we);
      end else begin
        check("rnd_we_idle", bus.out_we, 2'b00);
      end
      exp_take = (sb.size() > 0) && bus.out_ready;
      exp_acc  = bus.in_valid && (sb.size() < 2);
      if (bus.flush) begin
        sb.delete();
      end else begin
        if (exp_take) void'(sb.pop_front());
        if (exp_acc) begin
          e.d = bus.in_data;
          e.we = bus.in_we;
          sb.push_back(e);
        end
      end
      if (exp_acc) seq++;
      step();
    end
    if (seq < 1000) check("rnd_timeout", 32'(seq), 32'd1000);
    drive(1'b0, {DW{1'b0}}, 2'b00, 1'b1, 1'b0);
    repeat (3) step();
    check("bubble_model", bus.bubble_cnt, exp_bub);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised, elastic pipeline-stage register that replaces the fixed-width MEM/WB-style latches between CPU stages. It carries an arbitrary payload plus a group of write-enable bits under a valid/ready handshake, using a two-slot skid buffer so back-pressure never combinationally reaches the upstream stage. It also provides a synchronous flush that squashes in-flight entries and a saturating bubble counter for pipeline performance measurement.

## Interface
Parameters:
- DATA_W, 103, payload width (pc4 32 + alu_c 32 + wR 5 + rdo 32 + rf_wsel 2).
- WE_W, 2, write-enable bits (e.g. rf_we, dram_we); these are forced to 0 whenever no valid entry is presented.
- CNT_W, 16, bubble counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept; registered.
- in_data  in  DATA_W  upstream payload.
- in_we  in  WE_W  upstream write enables.
- out_valid  out  1  main slot holds a valid entry.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  main-slot payload.
- out_we  out  WE_W  main-slot write enables ANDed with out_valid.
- bubble_cnt  out  CNT_W  saturating count of bubble cycles.

## Operation
- Two slots: main (drives the outputs) and skid.
- State, one of three:
  - EMPTY: neither slot valid.
  - ONE: main valid.
  - TWO: both slots valid.
- in_ready = (state != TWO), decoded from registered state only.
- Handshakes: accept = in_valid & in_ready; take = out_valid & out_ready.
- Transitions, when flush=0:
  - EMPTY: accept → ONE, main ← in.
  - ONE:
    - accept & take → ONE, main ← in.
    - accept & !take → TWO, skid ← in.
    - !accept & take → EMPTY.
    - otherwise hold.
  - TWO:
    - take → ONE, main ← skid.
    - otherwise hold. No accept is possible because in_ready=0.
- flush=1 has priority over everything:
  - Next state is EMPTY and both slots are invalidated.
  - An input offered in the same cycle is dropped, even if in_ready=1.
  - A take in the same cycle still counts as consumed downstream.
- Data registers are not cleared on pop or flush; only the valid bits change. out_we must read 0 whenever out_valid=0, including after a flush.
- bubble_cnt:
  - Increments when out_ready=1 & out_valid=0, i.e. downstream was idle and waiting.
  - Saturates at 2^CNT_W−1.
  - Only rst clears it; flush does not.
- Ordering is strictly FIFO. No entry is ever duplicated or reordered.

## Timing
- Reset (async): state EMPTY, out_valid 0, in_ready 1, out_data 0, out_we 0, bubble_cnt 0. Deassertion is synchronous to clk.
- Latency: 1 cycle from an accepted input to out_valid when the stage is EMPTY or ONE-with-take.
- Throughput: 1 entry/cycle with out_ready held high.
- Back-pressure: one stalled cycle with out_ready=0 in ONE fills the skid slot. in_ready falls the cycle after the skid fills and rises the cycle after the skid drains.
- No combinational path from out_ready to in_ready, or from in_* to out_*.
- Reset mid-operation discards both slots immediately, asynchronously.

## Structure
- Shared package pipe_pkg holds:
  - The state enum (ST_EMPTY, ST_ONE, ST_TWO).
  - Payload-width constants: WB_PAYLOAD_W=103, WB_WE_W=2.
  - RF_WSEL encodings, so every stage instance agrees on payload layout.
- One natural sub-module: sat_counter (parameter W; ports inc, q; async reset), used for bubble_cnt.
- Payload packing and unpacking is done by the instantiating stage, not inside this block.

## Test plan
- Reset: assert rst mid-stream with both slots full → out_valid=0, in_ready=1, out_we=0, bubble_cnt=0 immediately, without a clock edge.
- Streaming: send 0x1..0x8 with out_ready=1 → outputs 0x1..0x8 on consecutive cycles, 1-cycle latency, in_ready stays 1.
- Skid: stream 0xA, 0xB, 0xC; drop out_ready for 2 cycles after 0xA appears →
  - 0xB enters skid and in_ready=0 next cycle.
  - 0xC is held upstream.
  - Outputs are exactly 0xA, 0xB, 0xC with no loss.
- Flush: fill to TWO with in_we=2'b11; pulse flush while in_valid=1 with 0xD →
  - Next cycle: out_valid=0, out_we=0.
  - 0xD is never output.
  - in_ready=1.
- Bubbles: out_ready=1, in_valid=0 for 5 cycles → bubble_cnt=5. With CNT_W=3 for 10 cycles → bubble_cnt=7 (saturated).
- Random: random in_valid/out_ready at 50% with 1000 entries plus occasional flush → scoreboard confirms FIFO order, no duplicates, only flushed entries missing, out_we=0 whenever out_valid=0.
